// File: rtl/wb_mul32_master.sv
// Wishbone classic initiator: writes operands A/B to the multiplier window, reads back P, returns it.
// Optional per-transfer ack timeout is enabled by defining WBM_TIMEOUT_EN.
module wb_mul32_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam logic [DW-1:0] ADR_A = BASE_ADDR;
  localparam logic [DW-1:0] ADR_B = DW'(BASE_ADDR + 32'd4);
  localparam logic [DW-1:0] ADR_P = DW'(BASE_ADDR + 32'd8);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_A  = 3'd1,
    GAP_A = 3'd2,
    WR_B  = 3'd3,
    GAP_B = 3'd4,
    RD_P  = 3'd5,
    RESP  = 3'd6
  } state_e;

  state_e        state_q;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] rsp_data_q;
  logic          cmd_ready_q, rsp_valid_q, busy_q;
  logic          cyc_q, stb_q, we_q;
  logic [SW-1:0] sel_q;
  logic [DW-1:0] adr_q, dat_q;

  logic          launch_c, xfer_c, abort_c;
  logic          we_d;
  logic [DW-1:0] adr_d, dat_d;

  assign xfer_c = stb_q & wbm_ack_i;

  // Next bus transfer: WR_A launches the cycle after acceptance, the gaps launch WR_B / RD_P.
  always_comb begin
    launch_c = 1'b0;
    we_d     = 1'b0;
    adr_d    = '0;
    dat_d    = '0;
    case (state_q)
      WR_A: begin
        launch_c = ~stb_q;
        we_d     = 1'b1;
        adr_d    = ADR_A;
        dat_d    = a_q;
      end
      GAP_A: begin
        launch_c = 1'b1;
        we_d     = 1'b1;
        adr_d    = ADR_B;
        dat_d    = b_q;
      end
      GAP_B: begin
        launch_c = 1'b1;
        adr_d    = ADR_P;
      end
      default: ;
    endcase
  end

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] to_cnt_q;
  logic          rsp_err_q;

  // An ack in the limit cycle wins over the abort.
  assign abort_c = stb_q & ~wbm_ack_i & (to_cnt_q == TO_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
    end else if (!stb_q) begin
      to_cnt_q <= '0;
    end else if (!wbm_ack_i) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == RD_P && xfer_c) begin
      rsp_err_q <= 1'b0;
    end else if (abort_c) begin
      rsp_err_q <= 1'b1;
    end else if (state_q == RESP && rsp_ready_i) begin
      rsp_err_q <= 1'b0;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign abort_c   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Registered Wishbone master outputs; address/data/we are zero whenever cyc is low.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (launch_c) begin
      cyc_q <= 1'b1;
      stb_q <= 1'b1;
      we_q  <= we_d;
      sel_q <= '1;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end else if (xfer_c || abort_c) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end
  end

  // Sequencer and command/response handshakes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_ready_q && cmd_valid_i) begin
            a_q         <= cmd_a_i;
            b_q         <= cmd_b_i;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= WR_A;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        WR_A, WR_B: begin
          if (xfer_c) begin
            state_q <= (state_q == WR_A) ? GAP_A : GAP_B;
          end else if (abort_c) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        GAP_A: state_q <= WR_B;
        GAP_B: state_q <= RD_P;
        RD_P: begin
          if (xfer_c) begin
            rsp_data_q  <= wbm_dat_i;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (abort_c) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = busy_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_mul32_master.sv
// Bench for wb_mul32_master: table-driven transactions against a behavioural multiplier slave,
// plus hand sequences for held responses, mid-transfer reset and (with WBM_TIMEOUT_EN) ack timeout.
`timescale 1ns/1ps
module tb_wb_mul32_master;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int unsigned TO   = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int unsigned waits;
    logic [31:0] exp_p;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, busy;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;

  always #5 clk = ~clk;

  wb_mul32_master #(.BASE_ADDR(BASE), .TO_CYCLES(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_a_i    (cmd_a),
    .cmd_b_i    (cmd_b),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (wb_cyc),
    .wbm_stb_o  (wb_stb),
    .wbm_we_o   (wb_we),
    .wbm_sel_o  (wb_sel),
    .wbm_adr_o  (wb_adr),
    .wbm_dat_o  (wb_dat_o),
    .wbm_dat_i  (wb_dat_i),
    .wbm_ack_i  (wb_ack),
    .busy_o     (busy)
  );

  // Behavioural multiplier slave with programmable wait states.
  int unsigned slave_waits = 0;
  int unsigned wcnt = 0;
  logic        no_ack_rd = 1'b0;
  logic        spur_ack = 1'b0;
  logic [31:0] sa = '0;
  logic [31:0] sb = '0;
  logic        slave_ack;
  int          edge_cnt = 0;
  xfer_t       log_q[$];
  int          start_q[$];
  rsp_t        sb_q[$];

  assign slave_ack = wb_stb && (wcnt == slave_waits) && !(no_ack_rd && !wb_we);
  assign wb_ack    = slave_ack || spur_ack;
  assign wb_dat_i  = (wb_stb && !wb_we && wb_adr == BASE + 32'd8) ? 32'(sa * sb) : 32'hBAD0_0000;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (wb_stb && !wb_ack) wcnt <= wcnt + 1;
    else                   wcnt <= 0;
    if (wb_stb && wb_ack) begin
      log_q.push_back('{we: wb_we, adr: wb_adr, dat: wb_dat_o});
      if (wb_we && wb_adr == BASE)         sa <= wb_dat_o;
      if (wb_we && wb_adr == BASE + 32'd4) sb <= wb_dat_o;
    end
  end

  // Bus-rule monitor and transfer-start recorder.
  logic prev_stb = 1'b0;
  int   rule_viol = 0;
  int   rd_stb_total = 0;
  logic rule_bad;
  assign rule_bad = (wb_cyc !== wb_stb) || (wb_cyc && wb_sel !== 4'hF) ||
                    (!wb_cyc && (wb_we || wb_adr != 32'd0 || wb_dat_o != 32'd0));

  always @(negedge clk) begin
    if (wb_stb && !prev_stb) start_q.push_back(edge_cnt);
    prev_stb <= wb_stb;
    if (!rst && rule_bad) rule_viol <= rule_viol + 1;
    if (wb_stb && !wb_we) rd_stb_total <= rd_stb_total + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Called at a negedge; returns the edge count seen at the negedge after the accepting edge.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, output int acc);
    int budget;
    budget    = 200;
    acc       = -1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    while (budget > 0) begin
      if (cmd_ready) begin
        @(negedge clk);
        acc = edge_cnt;
        break;
      end
      @(negedge clk);
      budget--;
    end
    cmd_valid = 1'b0;
    if (acc < 0) fail("cmd_accept");
  endtask

  task automatic recv_rsp(input int hold, output int valid_edge, output int hs_edge);
    rsp_t        exp;
    logic [31:0] d0;
    logic        e0, moved, rdy_seen;
    int          budget;
    budget     = 400;
    valid_edge = -1;
    hs_edge    = -1;
    while (budget > 0 && !rsp_valid) begin
      @(negedge clk);
      budget--;
    end
    if (!rsp_valid) begin
      fail("rsp_valid");
      return;
    end
    valid_edge = edge_cnt;
    if (sb_q.size() == 0) begin
      fail("scoreboard_entry");
    end else begin
      exp = sb_q.pop_front();
      check("rsp_data", rsp_data, exp.data);
      check("rsp_err", 32'(rsp_err), 32'(exp.err));
    end
    d0 = rsp_data;
    e0 = rsp_err;
    moved = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_data !== d0 || rsp_err !== e0 || !rsp_valid) moved = 1'b1;
      if (cmd_ready) rdy_seen = 1'b1;
    end
    if (hold > 0) begin
      check("rsp_held_stable", 32'(moved), 32'd0);
      check("cmd_ready_low_while_held", 32'(rdy_seen), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    hs_edge = edge_cnt;
    check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    check("cmd_ready_at_hs_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int acc, ve, hs;
    slave_waits = v.waits;
    log_q.delete();
    start_q.delete();
    sb_q.push_back('{data: v.exp_p, err: 1'b0});
    send_cmd(v.a, v.b, acc);
    if (acc < 0) return;
    recv_rsp(0, ve, hs);
    check("latency", 32'(ve - acc), 32'(v.lat));
    check("bus_xfer_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check("wr_a_adr", log_q[0].adr, BASE);
      check("wr_a_dat", log_q[0].dat, v.a);
      check("wr_a_we", 32'(log_q[0].we), 32'd1);
      check("wr_b_adr", log_q[1].adr, BASE + 32'd4);
      check("wr_b_dat", log_q[1].dat, v.b);
      check("wr_b_we", 32'(log_q[1].we), 32'd1);
      check("rd_p_adr", log_q[2].adr, BASE + 32'd8);
      check("rd_p_we", 32'(log_q[2].we), 32'd0);
    end
    check("stb_start_count", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("wr_a_launch", 32'(start_q[0] - acc), 32'd1);
      check("gap_a_spacing", 32'(start_q[1] - start_q[0]), 32'(v.waits + 2));
      check("gap_b_spacing", 32'(start_q[2] - start_q[1]), 32'(v.waits + 2));
    end
  endtask

  vec_t vecs[7];

  initial begin
    int   acc, ve, hs, budget, rd_before;
    logic bad;

    vecs[0] = '{32'd7,         32'd6,         0, 32'd42,        6};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2,         3, 32'hFFFF_FFFE, 15};
    vecs[2] = '{32'd0,         32'd12345,     1, 32'd0,         9};
    vecs[3] = '{32'h0001_0000, 32'h0001_0000, 2, 32'd0,         12};
    vecs[4] = '{32'h1234_5678, 32'd1,         0, 32'h1234_5678, 6};
    vecs[5] = '{32'd3,         32'h5555_5555, 1, 32'hFFFF_FFFF, 9};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'd1,         12};

    // Reset values, then cmd_ready rises on the first edge after release.
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("cmd_ready_before_first_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_after_first_edge", 32'(cmd_ready), 32'd1);

    // Spurious ack while idle must not start anything.
    spur_ack = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || !cmd_ready || wb_cyc || rsp_valid) bad = 1'b1;
    end
    spur_ack = 1'b0;
    check("spurious_ack_ignored", 32'(bad), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Held response with a second command waiting behind it.
    slave_waits = 0;
    sb_q.push_back('{data: 32'd42, err: 1'b0});
    send_cmd(32'd7, 32'd6, acc);
    cmd_a = 32'd9;
    cmd_b = 32'd9;
    cmd_valid = 1'b1;
    recv_rsp(10, ve, hs);
    check("held_latency", 32'(ve - acc), 32'd6);
    sb_q.push_back('{data: 32'd81, err: 1'b0});
    send_cmd(32'd9, 32'd9, acc);
    check("second_cmd_accept_edge", 32'(acc - hs), 32'd2);
    recv_rsp(0, ve, hs);
    check("second_cmd_latency", 32'(ve - acc), 32'd6);

    // Reset pulsed during WR_B with stb high.
    slave_waits = 3;
    send_cmd(32'd5, 32'd7, acc);
    budget = 100;
    while (budget > 0 && !(wb_stb && wb_we && wb_adr == BASE + 32'd4)) begin
      @(negedge clk);
      budget--;
    end
    if (!(wb_stb && wb_we && wb_adr == BASE + 32'd4)) fail("reach_wr_b");
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc", 32'(wb_cyc), 32'd0);
    check("async_rst_stb", 32'(wb_stb), 32'd0);
    check("async_rst_we", 32'(wb_we), 32'd0);
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("post_rst_ready_high", 32'(cmd_ready), 32'd1);
    run_vec(vecs[1]);

`ifdef WBM_TIMEOUT_EN
    // Slave never acks the product read: abort after TO stb cycles.
    slave_waits = 0;
    no_ack_rd = 1'b1;
    rd_before = rd_stb_total;
    sb_q.push_back('{data: 32'd0, err: 1'b1});
    send_cmd(32'd5, 32'd5, acc);
    recv_rsp(0, ve, hs);
    check("timeout_rd_stb_cycles", 32'(rd_stb_total - rd_before), 32'(TO));
    no_ack_rd = 1'b0;
    run_vec(vecs[0]);
`else
    rd_before = rd_stb_total;
`endif

    check("bus_rule_violations", 32'(rule_viol), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("rd_stb_counter_monotonic", 32'(rd_stb_total >= rd_before), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0d ns, expected finish earlier", 100000);
    $fatal(1);
  end

endmodule
